// File: rtl/mem_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                |
// | Description : Two-requester arbiter in front of an AHB-Lite master port. |
// |               Grants one command per accepted address phase, pipelines   |
// |               address and data phases, and returns in-order completions. |
// |               Out-of-range commands skip the bus and complete with ERR.  |
// | Options     : MEM_ARBITER_ROUND_ROBIN_EN - round-robin tie break; when   |
// |               undefined requester 0 wins every tie.                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module mem_arbiter #(
  parameter int MEMWIDTH = 14
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic [31:0] ADDR0,
  input  logic [31:0] ADDR1,
  input  logic        WRITE0,
  input  logic        WRITE1,
  input  logic [2:0]  SIZE0,
  input  logic [2:0]  SIZE1,
  input  logic [31:0] WDATA0,
  input  logic [31:0] WDATA1,
  output logic        GNT0,
  output logic        GNT1,
  output logic        RVALID0,
  output logic        RVALID1,
  output logic        ERR0,
  output logic        ERR1,
  output logic [31:0] RDATA,
  output logic        HSEL,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA
);

  // Grant pulses
  logic        r_gnt0;
  logic        r_gnt1;
  // Address phase: valid covers both real transfers and error phantoms
  logic        r_ap_valid;
  logic        r_ap_id;
  logic        r_ap_err;
  logic        r_hsel;
  logic [31:0] r_haddr;
  logic        r_hwrite;
  logic [2:0]  r_hsize;
  logic [31:0] r_wdata_pend;
  // Data phase
  logic        r_dp_valid;
  logic        r_dp_id;
  logic        r_dp_err;
  logic        r_dp_write;
  logic [31:0] r_hwdata;
  // Completion
  logic        r_rvalid0;
  logic        r_rvalid1;
  logic        r_err0;
  logic        r_err1;
  logic [31:0] r_rdata;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic        r_rr_last;
`endif

  logic        w_oor0;
  logic        w_oor1;
  logic        w_elig0;
  logic        w_elig1;
  logic        w_arb_en;
  logic        w_win0;
  logic        w_win1;
  logic        w_grant;
  logic        w_sel_oor;
  logic [31:0] w_sel_addr;
  logic        w_sel_write;
  logic [2:0]  w_sel_size;
  logic [31:0] w_sel_wdata;
  logic        w_ap_adv;
  logic        w_dp_done;

  // Anything above the implemented memory window is an error
  assign w_oor0 = (ADDR0 >> MEMWIDTH) != 32'd0;
  assign w_oor1 = (ADDR1 >> MEMWIDTH) != 32'd0;

  // A requester is masked during its own GNT cycle so a held REQ is not regranted
  assign w_elig0  = REQ0 & ~r_gnt0;
  assign w_elig1  = REQ1 & ~r_gnt1;

  // New grants only when the pending address phase (if any) is being accepted
  assign w_arb_en = HREADY | ~r_ap_valid;
  assign w_ap_adv = r_ap_valid & HREADY;
  assign w_dp_done = r_dp_valid & HREADY;

  // Pick the winner among eligible requesters
  always_comb begin
    w_win0 = 1'b0;
    w_win1 = 1'b0;
    if (w_arb_en) begin
      if (w_elig0 && w_elig1) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        if (r_rr_last) begin
          w_win0 = 1'b1;
        end else begin
          w_win1 = 1'b1;
        end
`else
        w_win0 = 1'b1;
`endif
      end else begin
        w_win0 = w_elig0;
        w_win1 = w_elig1;
      end
    end
  end

  assign w_grant     = w_win0 | w_win1;
  assign w_sel_oor   = w_win1 ? w_oor1 : w_oor0;
  assign w_sel_addr  = w_win1 ? ADDR1  : ADDR0;
  assign w_sel_write = w_win1 ? WRITE1 : WRITE0;
  assign w_sel_size  = w_win1 ? SIZE1  : SIZE0;
  assign w_sel_wdata = w_win1 ? WDATA1 : WDATA0;

  // Grant pulse and address phase; held unchanged while the slave stalls it
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_ap_valid   <= 1'b0;
      r_ap_id      <= 1'b0;
      r_ap_err     <= 1'b0;
      r_hsel       <= 1'b0;
      r_haddr      <= 32'd0;
      r_hwrite     <= 1'b0;
      r_hsize      <= 3'd0;
      r_wdata_pend <= 32'd0;
    end else begin
      r_gnt0 <= w_win0;
      r_gnt1 <= w_win1;
      if (w_arb_en) begin
        r_ap_valid <= w_grant;
        r_ap_id    <= w_win1;
        r_ap_err   <= w_grant & w_sel_oor;
        r_hsel     <= w_grant & ~w_sel_oor;
        if (w_grant) begin
          r_wdata_pend <= w_sel_wdata;
        end
        if (w_grant && !w_sel_oor) begin
          r_haddr  <= w_sel_addr;
          r_hwrite <= w_sel_write;
          r_hsize  <= w_sel_size;
        end
      end
    end
  end

  // Data phase follows an accepted address phase; error phantoms flow through too to keep order
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_dp_valid <= 1'b0;
      r_dp_id    <= 1'b0;
      r_dp_err   <= 1'b0;
      r_dp_write <= 1'b0;
      r_hwdata   <= 32'd0;
    end else if (w_ap_adv) begin
      r_dp_valid <= 1'b1;
      r_dp_id    <= r_ap_id;
      r_dp_err   <= r_ap_err;
      r_dp_write <= r_hwrite & ~r_ap_err;
      if (r_hsel && r_hwrite) begin
        r_hwdata <= r_wdata_pend;
      end
    end else if (w_dp_done) begin
      r_dp_valid <= 1'b0;
    end
  end

  // Registered completion pulse with read data capture
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_err0    <= 1'b0;
      r_err1    <= 1'b0;
      r_rdata   <= 32'd0;
    end else begin
      r_rvalid0 <= w_dp_done & ~r_dp_id;
      r_rvalid1 <= w_dp_done &  r_dp_id;
      r_err0    <= w_dp_done & ~r_dp_id & r_dp_err;
      r_err1    <= w_dp_done &  r_dp_id & r_dp_err;
      if (w_dp_done && !r_dp_write && !r_dp_err) begin
        r_rdata <= HRDATA;
      end
    end
  end

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // Remember the last winner so the other side takes the next tie
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_rr_last <= 1'b0;
    end else if (w_grant) begin
      r_rr_last <= w_win1;
    end
  end
`endif

  assign GNT0    = r_gnt0;
  assign GNT1    = r_gnt1;
  assign RVALID0 = r_rvalid0;
  assign RVALID1 = r_rvalid1;
  assign ERR0    = r_err0;
  assign ERR1    = r_err1;
  assign RDATA   = r_rdata;
  assign HSEL    = r_hsel;
  assign HADDR   = r_haddr;
  assign HTRANS  = {r_hsel, 1'b0};
  assign HWRITE  = r_hwrite;
  assign HSIZE   = r_hsize;
  assign HWDATA  = r_hwdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                             |
// | Description : Scoreboard bench for mem_arbiter with a small AHB slave.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;

  logic        HCLK;
  logic        HRESETn;
  logic        REQ0, REQ1;
  logic [31:0] ADDR0, ADDR1;
  logic        WRITE0, WRITE1;
  logic [2:0]  SIZE0, SIZE1;
  logic [31:0] WDATA0, WDATA1;
  logic        GNT0, GNT1, RVALID0, RVALID1, ERR0, ERR1;
  logic [31:0] RDATA;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;

  typedef struct { logic rd; logic err; logic lat; logic [31:0] data; } exp_t;
  typedef struct { int id; logic [1:0] htrans; int cyc; } gnt_t;

  exp_t sb0[$];
  exp_t sb1[$];
  int   gcyc0[$];
  int   gcyc1[$];
  gnt_t gnt_log[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rv_cnt = 0;

  mem_arbiter #(.MEMWIDTH(14)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .REQ0(REQ0), .REQ1(REQ1), .ADDR0(ADDR0), .ADDR1(ADDR1),
    .WRITE0(WRITE0), .WRITE1(WRITE1), .SIZE0(SIZE0), .SIZE1(SIZE1),
    .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
    .ERR0(ERR0), .ERR1(ERR1), .RDATA(RDATA),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Tiny zero-wait slave: 16 words, stalls are driven through HREADY by the bench
  logic [31:0] smem [0:15];
  bit          s_init;
  logic        s_dvalid, s_dwrite;
  logic [31:0] s_daddr;

  always @(posedge HCLK) begin
    if (!s_init) begin
      for (int i = 0; i < 16; i++) smem[i] <= 32'hA500_0000 | i;
      smem[4] <= 32'hDEAD_BEEF;
      s_init  <= 1'b1;
    end else if (HREADY && s_dvalid && s_dwrite) begin
      smem[s_daddr[5:2]] <= HWDATA;
    end
    if (!HRESETn) begin
      s_dvalid <= 1'b0;
      s_dwrite <= 1'b0;
      s_daddr  <= 32'd0;
    end else if (HREADY) begin
      s_dvalid <= HSEL && (HTRANS == 2'b10);
      s_daddr  <= HADDR;
      s_dwrite <= HWRITE;
    end
  end

  assign HRDATA = (s_dvalid && !s_dwrite) ? smem[s_daddr[5:2]] : 32'd0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, expv);
    end
  endtask

  // Pop the requester's expectation on every completion pulse
  task automatic sb_check(input int id, input logic err, input logic [31:0] rd);
    exp_t e;
    int   g;
    int   have;
    rv_cnt++;
    have = (id == 0) ? sb0.size() : sb1.size();
    check($sformatf("sb_nonempty%0d", id), (have != 0) ? 32'd1 : 32'd0, 32'd1);
    if (have != 0) begin
      if (id == 0) e = sb0.pop_front(); else e = sb1.pop_front();
      g = -1000;
      if (id == 0 && gcyc0.size() != 0) g = gcyc0.pop_front();
      if (id == 1 && gcyc1.size() != 0) g = gcyc1.pop_front();
      check($sformatf("err%0d", id), {31'd0, err}, {31'd0, e.err});
      if (e.rd && !e.err) check($sformatf("rdata%0d", id), rd, e.data);
      if (e.lat) check($sformatf("latency%0d", id), cyc - g, 32'd2);
    end
  endtask

  task automatic issue(input int id, input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input logic [31:0] ed, input logic ee,
                       input logic lat, input logic push, output int waited);
    exp_t e;
    logic got;
    e.rd = !w; e.err = ee; e.lat = lat; e.data = ed;
    if (push) begin
      if (id == 0) sb0.push_back(e); else sb1.push_back(e);
    end
    if (id == 0) begin
      REQ0 = 1'b1; ADDR0 = a; WRITE0 = w; SIZE0 = 3'd2; WDATA0 = wd;
    end else begin
      REQ1 = 1'b1; ADDR1 = a; WRITE1 = w; SIZE1 = 3'd2; WDATA1 = wd;
    end
    got = 1'b0;
    waited = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge HCLK);
      got = (id == 0) ? GNT0 : GNT1;
      if (!got) waited++;
    end
    check($sformatf("gnt_wait%0d", id), {31'd0, got}, 32'd1);
    if (id == 0) REQ0 = 1'b0; else REQ1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, wa, wb, base, cnt, rv_before;
    int exp_order [4];
    gnt_t ge;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    exp_order = '{1, 0, 1, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    HRESETn = 1'b0; HREADY = 1'b1;
    REQ0 = 1'b0; ADDR0 = 32'd0; WRITE0 = 1'b0; SIZE0 = 3'd0; WDATA0 = 32'd0;
    REQ1 = 1'b0; ADDR1 = 32'd0; WRITE1 = 1'b0; SIZE1 = 3'd0; WDATA1 = 32'd0;

    // Monitor: completions checked before new grants are logged in the same cycle
    fork
      forever begin
        @(negedge HCLK);
        cyc++;
        if (RVALID0) sb_check(0, ERR0, RDATA);
        if (RVALID1) sb_check(1, ERR1, RDATA);
        if (GNT0) begin
          gcyc0.push_back(cyc);
          ge.id = 0; ge.htrans = HTRANS; ge.cyc = cyc; gnt_log.push_back(ge);
        end
        if (GNT1) begin
          gcyc1.push_back(cyc);
          ge.id = 1; ge.htrans = HTRANS; ge.cyc = cyc; gnt_log.push_back(ge);
        end
      end
    join_none

    // Power-on reset values
    repeat (3) @(negedge HCLK);
    check("rst_ctl", {23'd0, GNT0, GNT1, RVALID0, RVALID1, ERR0, ERR1, HSEL, HWRITE, HTRANS}, 32'd0);
    check("rst_haddr", HADDR, 32'd0);
    check("rst_hsize", {29'd0, HSIZE}, 32'd0);
    check("rst_hwdata", HWDATA, 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // Single read: grant next cycle, completion two cycles after grant
    issue(0, 32'h10, 1'b0, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, w);
    check("rd_gnt_delay", w, 32'd0);
    check("rd_haddr", HADDR, 32'h10);
    check("rd_htrans", {30'd0, HTRANS}, 32'd2);
    repeat (4) @(negedge HCLK);

    // Write held in a 3-cycle stalled data phase while requester 1 queues a read
    issue(0, 32'h20, 1'b1, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b1, w);
    @(negedge HCLK);
    HREADY = 1'b0;
    base = gnt_log.size();
    fork
      issue(1, 32'h14, 1'b0, 32'd0, 32'hA500_0005, 1'b0, 1'b0, 1'b1, wa);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge HCLK);
          check("stall_hwdata", HWDATA, 32'h1234_5678);
          check("stall_haddr", HADDR, 32'h14);
          check("stall_htrans", {30'd0, HTRANS}, 32'd2);
          check("stall_no_rvalid", {31'd0, RVALID0}, 32'd0);
        end
        HREADY = 1'b1;
        @(negedge HCLK);
        check("stall_rvalid", {31'd0, RVALID0}, 32'd1);
      end
    join
    repeat (4) @(negedge HCLK);
    cnt = 0;
    for (int i = base; i < gnt_log.size(); i++) if (gnt_log[i].id == 1) cnt++;
    check("stall_gnt1_once", cnt, 32'd1);

    // Out-of-range address: grant, no bus transfer, error completion
    issue(1, 32'h0000_4000, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, w);
    check("oor_gnt_delay", w, 32'd0);
    check("oor_idle0", {29'd0, HSEL, HTRANS}, 32'd0);
    @(negedge HCLK);
    check("oor_idle1", {29'd0, HSEL, HTRANS}, 32'd0);
    repeat (4) @(negedge HCLK);

    // Reset during a data phase abandons the transfer
    issue(0, 32'h10, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, w);
    @(negedge HCLK);
    HRESETn = 1'b0;
    @(negedge HCLK);
    check("mrst_ctl", {23'd0, GNT0, GNT1, RVALID0, RVALID1, ERR0, ERR1, HSEL, HWRITE, HTRANS}, 32'd0);
    check("mrst_haddr", HADDR, 32'd0);
    check("mrst_hsize", {29'd0, HSIZE}, 32'd0);
    check("mrst_hwdata", HWDATA, 32'd0);
    check("mrst_rdata", RDATA, 32'd0);
    HRESETn = 1'b1;
    gcyc0.delete();
    rv_before = rv_cnt;
    repeat (6) @(negedge HCLK);
    check("mrst_no_rvalid", rv_cnt, rv_before);

    // Both requesters held for two commands each: alternating back-to-back grants
    base = gnt_log.size();
    fork
      begin
        issue(0, 32'h24, 1'b1, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b1, 1'b1, wa);
        issue(0, 32'h20, 1'b0, 32'd0, 32'h1234_5678, 1'b0, 1'b1, 1'b1, wa);
      end
      begin
        issue(1, 32'h00, 1'b0, 32'd0, 32'hA500_0000, 1'b0, 1'b1, 1'b1, wb);
        issue(1, 32'h24, 1'b0, 32'd0, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b1, wb);
      end
    join
    repeat (6) @(negedge HCLK);
    check("tie_gnt_count", gnt_log.size() - base, 32'd4);
    if (gnt_log.size() >= base + 4) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("tie_order%0d", k), gnt_log[base+k].id, exp_order[k]);
        check($sformatf("tie_htrans%0d", k), {30'd0, gnt_log[base+k].htrans}, 32'd2);
        check($sformatf("tie_cycle%0d", k), gnt_log[base+k].cyc - gnt_log[base].cyc, k);
      end
    end

    check("sb0_drained", sb0.size(), 32'd0);
    check("sb1_drained", sb1.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
